// File: rtl/lsu_mem_req_if.sv
// LSU bundle: EX op in, single-word dmem request/response, raw load word out to WB.
// master = the LSU (drives ex_ready, dmem request, WB); slave = surrounding pipeline and memory.
interface lsu_mem_req_if;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic        ex_ready;

  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;

  logic        wb_valid;
  logic [31:0] wb_load_raw;
  logic [1:0]  wb_addr_offset;
  logic [2:0]  wb_control_load;

  modport master (
    input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
    output ex_ready,
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
    output wb_valid, wb_load_raw, wb_addr_offset, wb_control_load
  );

  modport slave (
    output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
    input  ex_ready,
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
    input  wb_valid, wb_load_raw, wb_addr_offset, wb_control_load
  );
endinterface

// File: rtl/lsu_mem_req.sv
// LSU request sequencer: accept N, dmem request from N+1 held until ready, wb_valid the cycle after the response.
// EX is stalled (ex_ready=0) outside IDLE; define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module lsu_mem_req (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_req_if.master bus,
  output logic          misalign
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  we_q;
  logic [2:0]  funct3_q;
  logic        is_load_q;

  logic        wb_valid_q;
  logic [31:0] wb_raw_q;
  logic [1:0]  wb_off_q;
  logic [2:0]  wb_ctl_q;

  logic        accept;
  logic        take_load;
  logic        take_store;
  logic        op_legal;
  logic        trap;
  logic        issue;
  logic [3:0]  we_d;
  logic [31:0] wdata_d;

  assign accept     = (state == IDLE) & bus.ex_valid;
  assign take_load  = bus.ex_is_load;
  assign take_store = bus.ex_is_store & ~bus.ex_is_load;

  always_comb begin
    op_legal = 1'b0;
    if (take_load)
      op_legal = bus.ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (take_store)
      op_legal = bus.ex_funct3 inside {3'b000, 3'b001, 3'b010};
  end

  assign issue = accept & op_legal & ~trap;

  // Byte lanes and replicated data are resolved at accept so the request stays stable while stalled.
  always_comb begin
    we_d    = 4'b0000;
    wdata_d = bus.ex_store_data;
    if (take_store) begin
      case (bus.ex_funct3[1:0])
        2'b00: begin
          we_d    = 4'b0001 << bus.ex_addr[1:0];
          wdata_d = {4{bus.ex_store_data[7:0]}};
        end
        2'b01: begin
          we_d    = bus.ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{bus.ex_store_data[15:0]}};
        end
        default: we_d = 4'b1111;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_comb begin
    trap = 1'b0;
    case (bus.ex_funct3[1:0])
      2'b01:   trap = bus.ex_addr[0];
      2'b10:   trap = |bus.ex_addr[1:0];
      default: trap = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_q <= 1'b0;
    else
      misalign_q <= accept & op_legal & trap;
  end

  assign misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 4'h0;
      funct3_q   <= 3'h0;
      is_load_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_raw_q   <= 32'h0;
      wb_off_q   <= 2'h0;
      wb_ctl_q   <= 3'h0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            addr_q    <= bus.ex_addr;
            funct3_q  <= bus.ex_funct3;
            is_load_q <= take_load;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.dmem_req_ready)
            state <= is_load_q ? WAIT_RESP : IDLE;
        end
        WAIT_RESP: begin
          if (bus.dmem_resp_valid) begin
            wb_valid_q <= 1'b1;
            wb_raw_q   <= bus.dmem_resp_data;
            wb_off_q   <= addr_q[1:0];
            wb_ctl_q   <= funct3_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready        = (state == IDLE);
  assign bus.dmem_req_valid  = (state == REQ);
  assign bus.dmem_addr       = {addr_q[31:2], 2'b00};
  assign bus.dmem_we         = we_q;
  assign bus.dmem_wdata      = wdata_q;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_load_raw     = wb_raw_q;
  assign bus.wb_addr_offset  = wb_off_q;
  assign bus.wb_control_load = wb_ctl_q;
endmodule
